// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared op codes, sizes, exception causes and FSM states for the load/store unit (rev 1.0)
`default_nettype none

package lsu_pkg;

   localparam logic [2:0] OP_LB   = 3'b000;
   localparam logic [2:0] OP_LH   = 3'b001;
   localparam logic [2:0] OP_LW   = 3'b010;
   localparam logic [2:0] OP_IDLE = 3'b011;
   localparam logic [2:0] OP_SB   = 3'b100;
   localparam logic [2:0] OP_SH   = 3'b101;
   localparam logic [2:0] OP_SW   = 3'b111;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ACCESS   = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_STORE = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_t;

   // Only meaningful for sizes that passed the legality check.
   function automatic logic [2:0] op_code_of(input logic store, input logic [1:0] size);
      logic [2:0] op;
      op = OP_IDLE;
      case ({store, size})
         {1'b0, SZ_BYTE}: op = OP_LB;
         {1'b0, SZ_HALF}: op = OP_LH;
         {1'b0, SZ_WORD}: op = OP_LW;
         {1'b1, SZ_BYTE}: op = OP_SB;
         {1'b1, SZ_HALF}: op = OP_SH;
         {1'b1, SZ_WORD}: op = OP_SW;
         default:         op = OP_IDLE;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_addr_check.sv
// lsu_addr_check -- combinational legality, region and alignment check of a memory request (rev 1.0)
`default_nettype none

module lsu_addr_check
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic        load,
   input  logic        store,
   output logic        fault,
   output logic [1:0]  cause
);

   logic region_ok;
   logic unused_addr_bits;

   // Only the two data-RAM windows 0x400-0x7FF and 0x800-0xBFF are mapped.
   assign region_ok        = (addr[11:10] == 2'b01) || (addr[11:10] == 2'b10);
   assign unused_addr_bits = ^addr[13:12];

   always_comb begin
      fault = 1'b1;
      cause = CAUSE_NONE;
      if ((load && store) || (size == SZ_ILL)) begin
         cause = CAUSE_ILLEGAL;
      end else if ((addr[31:14] != 18'd0) || !region_ok) begin
         cause = CAUSE_ACCESS;
      end else if (((size == SZ_HALF) && addr[0]) ||
                   ((size == SZ_WORD) && (addr[1:0] != 2'b00))) begin
         cause = CAUSE_MISALIGN;
      end else begin
         fault = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store control stage: checks a request, holds it on the memory port, returns load data (rev 1.0)
`default_nettype none

module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int LOAD_LAT  = 3,
   parameter int STORE_LAT = 3,
   parameter int CNT_W     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_load,
   input  logic        ex_store,
   input  logic [1:0]  ex_size,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [4:0]  ex_rd,
   output logic [2:0]  mem_op_code,
   output logic [13:0] mem_rwaddr,
   output logic [31:0] mem_wdata,
   output logic        mem_stall,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        store_done,
   output logic        exc_valid,
   output logic [1:0]  exc_cause,
   output logic [31:0] exc_addr
);

   lsu_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             resp_load, resp_load_n;
   logic [4:0]       rd_lat, rd_lat_n;

   logic             ready_n, stall_n, wb_valid_n, store_done_n, exc_valid_n;
   logic [2:0]       op_n;
   logic [13:0]      rwaddr_n;
   logic [31:0]      wdata_n, wb_data_n, exc_addr_n;
   logic [4:0]       wb_rd_n;
   logic [1:0]       exc_cause_n;

   logic             chk_fault;
   logic [1:0]       chk_cause;
   logic             accept;

   lsu_addr_check u_addr_check (
      .size  (ex_size),
      .addr  (ex_addr),
      .load  (ex_load),
      .store (ex_store),
      .fault (chk_fault),
      .cause (chk_cause)
   );

   // A valid with neither load nor store set is not a request at all.
   assign accept = ex_valid && ex_ready && (ex_load || ex_store);

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      resp_load_n  = resp_load;
      rd_lat_n     = rd_lat;
      op_n         = mem_op_code;
      rwaddr_n     = mem_rwaddr;
      wdata_n      = mem_wdata;
      stall_n      = mem_stall;
      wb_valid_n   = 1'b0;
      wb_rd_n      = wb_rd;
      wb_data_n    = wb_data;
      store_done_n = 1'b0;
      exc_valid_n  = 1'b0;
      exc_cause_n  = exc_cause;
      exc_addr_n   = exc_addr;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (chk_fault) begin
                  state_n     = ST_RESP;
                  resp_load_n = 1'b0;
                  exc_valid_n = 1'b1;
                  exc_cause_n = chk_cause;
                  exc_addr_n  = ex_addr;
               end else begin
                  state_n     = ex_load ? ST_LOAD : ST_STORE;
                  cnt_n       = CNT_W'(1);
                  resp_load_n = ex_load;
                  rd_lat_n    = ex_rd;
                  op_n        = op_code_of(ex_store, ex_size);
                  rwaddr_n    = ex_addr[13:0];
                  stall_n     = 1'b0;
                  if (ex_store) begin
                     wdata_n = ex_wdata;
                  end
               end
            end
         end
         ST_LOAD: begin
            if (cnt == CNT_W'(LOAD_LAT)) begin
               state_n = ST_RESP;
               cnt_n   = '0;
               op_n    = OP_IDLE;
               stall_n = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_STORE: begin
            if (cnt == CNT_W'(STORE_LAT)) begin
               state_n      = ST_IDLE;
               cnt_n        = '0;
               op_n         = OP_IDLE;
               stall_n      = 1'b1;
               store_done_n = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_RESP: begin
            // Load data is valid on mem_rdata during this cycle; faults just drain.
            state_n = ST_IDLE;
            if (resp_load) begin
               wb_valid_n = 1'b1;
               wb_data_n  = mem_rdata;
               wb_rd_n    = rd_lat;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            op_n    = OP_IDLE;
            stall_n = 1'b1;
         end
      endcase

      ready_n = (state_n == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         resp_load   <= 1'b0;
         rd_lat      <= '0;
         ex_ready    <= 1'b1;
         mem_op_code <= OP_IDLE;
         mem_rwaddr  <= '0;
         mem_wdata   <= '0;
         mem_stall   <= 1'b1;
         wb_valid    <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         store_done  <= 1'b0;
         exc_valid   <= 1'b0;
         exc_cause   <= CAUSE_NONE;
         exc_addr    <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         resp_load   <= resp_load_n;
         rd_lat      <= rd_lat_n;
         ex_ready    <= ready_n;
         mem_op_code <= op_n;
         mem_rwaddr  <= rwaddr_n;
         mem_wdata   <= wdata_n;
         mem_stall   <= stall_n;
         wb_valid    <= wb_valid_n;
         wb_rd       <= wb_rd_n;
         wb_data     <= wb_data_n;
         store_done  <= store_done_n;
         exc_valid   <= exc_valid_n;
         exc_cause   <= exc_cause_n;
         exc_addr    <= exc_addr_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ((2 ** CNT_W) > LOAD_LAT && (2 ** CNT_W) > STORE_LAT);
         assert (state != ST_LOAD  || (cnt != '0 && cnt <= CNT_W'(LOAD_LAT)));
         assert (state != ST_STORE || (cnt != '0 && cnt <= CNT_W'(STORE_LAT)));
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- directed and randomized checks of lsu_ctrl against a request-level reference model (rev 1.0)
`default_nettype none

module tb_lsu_ctrl;

   localparam int LOAD_LAT  = 3;
   localparam int STORE_LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready, ex_load, ex_store;
   logic [1:0]  ex_size;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_rd;
   logic [2:0]  mem_op_code;
   logic [13:0] mem_rwaddr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        store_done, exc_valid;
   logic [1:0]  exc_cause;
   logic [31:0] exc_addr;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.LOAD_LAT(LOAD_LAT), .STORE_LAT(STORE_LAT), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
      .ex_size(ex_size), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
      .mem_op_code(mem_op_code), .mem_rwaddr(mem_rwaddr), .mem_wdata(mem_wdata),
      .mem_stall(mem_stall), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .store_done(store_done),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Exception cause straight from the request rules; 0 means the request is legal.
   function automatic logic [1:0] ref_cause(input bit ld, input bit st, input logic [1:0] sz,
                                            input logic [31:0] a);
      if ((ld && st) || sz == 2'd3) return 2'd3;
      if (a[31:14] != 0 || !(a[11:10] == 2'd1 || a[11:10] == 2'd2)) return 2'd2;
      if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0)) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [2:0] ref_op(input bit st, input logic [1:0] sz);
      logic [2:0] tbl [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111};
      return tbl[(st ? 3 : 0) + int'(sz)];
   endfunction

   task automatic check_cyc(input string tag, input logic [2:0] op, input logic stall,
                            input logic ready, input logic wb, input logic sd, input logic exc);
      check_val({tag, ".op"},    32'(mem_op_code), 32'(op));
      check_val({tag, ".stall"}, 32'(mem_stall),   32'(stall));
      check_val({tag, ".ready"}, 32'(ex_ready),    32'(ready));
      check_val({tag, ".wbv"},   32'(wb_valid),    32'(wb));
      check_val({tag, ".sdone"}, 32'(store_done),  32'(sd));
      check_val({tag, ".excv"},  32'(exc_valid),   32'(exc));
   endtask

   task automatic idle_cycle();
      step();
      check_cyc("idle", 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Presents one request in the current cycle and follows it until ex_ready returns.
   task automatic run_req(input string nm, input bit ld, input bit st, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input bit keep);
      logic [1:0] cause;
      logic [2:0] op;
      cause    = ref_cause(ld, st, sz, a);
      op       = ref_op(st, sz);
      ex_valid = 1'b1;
      ex_load  = ld;
      ex_store = st;
      ex_size  = sz;
      ex_addr  = a;
      ex_wdata = wd;
      ex_rd    = rd;
      check_val({nm, ".pre_ready"}, 32'(ex_ready), 32'd1);
      step();
      if (!keep) ex_valid = 1'b0;
      if (!ld && !st) begin
         check_cyc({nm, ".ignored"}, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end else if (cause != 2'd0) begin
         check_cyc({nm, ".exc1"}, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         check_val({nm, ".cause"}, 32'(exc_cause), 32'(cause));
         check_val({nm, ".exc_addr"}, exc_addr, a);
         step();
         check_cyc({nm, ".exc2"}, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end else if (ld) begin
         mem_rdata = $urandom;
         for (int k = 1; k <= LOAD_LAT; k++) begin
            check_cyc($sformatf("%s.ld_hold%0d", nm, k), op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_val($sformatf("%s.ld_addr%0d", nm, k), 32'(mem_rwaddr), 32'(a[13:0]));
            step();
         end
         mem_rdata = rdata;
         check_cyc({nm, ".ld_resp"}, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         step();
         mem_rdata = $urandom;
         check_cyc({nm, ".ld_wb"}, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         check_val({nm, ".wb_data"}, wb_data, rdata);
         check_val({nm, ".wb_rd"}, 32'(wb_rd), 32'(rd));
      end else begin
         for (int k = 1; k <= STORE_LAT; k++) begin
            check_cyc($sformatf("%s.st_hold%0d", nm, k), op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_val($sformatf("%s.st_addr%0d", nm, k), 32'(mem_rwaddr), 32'(a[13:0]));
            check_val($sformatf("%s.st_wdata%0d", nm, k), mem_wdata, wd);
            step();
         end
         check_cyc({nm, ".st_done"}, 3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[31:14] = '0;
      if ($urandom_range(0, 5) != 0) a[11:10] = 2'($urandom_range(1, 2));
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      return a;
   endfunction

   initial begin
      rst = 1'b1;  ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
      ex_size = 2'b00; ex_addr = '0; ex_wdata = '0; ex_rd = '0; mem_rdata = '0;
      step();
      step();
      check_cyc("reset", 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_val("reset.wb_data", wb_data, 32'd0);
      check_val("reset.rwaddr", 32'(mem_rwaddr), 32'd0);
      rst = 1'b0;
      idle_cycle();

      run_req("lw404",  1, 0, 2'b10, 32'h0000_0404, 32'h0, 5'd7, 32'hDEAD_BEEF, 0);
      idle_cycle();
      run_req("sb803",  0, 1, 2'b00, 32'h0000_0803, 32'h0000_00A5, 5'd0, 32'h0, 0);
      idle_cycle();
      run_req("lh405",  1, 0, 2'b01, 32'h0000_0405, 32'h0, 5'd3, 32'h0, 0);
      run_req("lwC00",  1, 0, 2'b10, 32'h0000_0C00, 32'h0, 5'd3, 32'h0, 0);
      run_req("lw10400",1, 0, 2'b10, 32'h0001_0400, 32'h0, 5'd3, 32'h0, 0);
      run_req("ldst",   1, 1, 2'b10, 32'h0000_0400, 32'h0, 5'd3, 32'h0, 0);
      run_req("ignored",0, 0, 2'b10, 32'h0000_0400, 32'h0, 5'd3, 32'h0, 0);
      run_req("busy1",  1, 0, 2'b10, 32'h0000_0408, 32'h0, 5'd9, 32'h1234_5678, 1);
      run_req("busy2",  1, 0, 2'b00, 32'h0000_080D, 32'h0, 5'd31, 32'hFFFF_FF80, 0);
      idle_cycle();

      // Reset during the load hold phase aborts the access.
      ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_size = 2'b10; ex_addr = 32'h0000_0410;
      step();
      ex_valid = 1'b0;
      step();
      check_cyc("pre_abort", 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_cyc("abort", 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycle();
      idle_cycle();

      for (int n = 0; n < 80; n++) begin
         int r;
         bit ld, st, keep;
         r    = $urandom_range(0, 11);
         ld   = (r == 0) || (r >= 2 && r < 7);
         st   = (r == 0) || (r >= 7);
         keep = ($urandom_range(0, 3) == 0) && (ld || st) && (n != 79);
         run_req($sformatf("rnd%0d", n), ld, st, 2'($urandom_range(0, 3)), rand_addr(),
                 $urandom, 5'($urandom_range(0, 31)), $urandom, keep);
         if (!keep && $urandom_range(0, 1) == 1) idle_cycle();
      end
      ex_valid = 1'b0;
      idle_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
